converter_ctrl: RTL and testbench
=================================

# converter_ctrl

Frame-level sequencer for the `converter` RGB-to-luma pipeline. It accepts a valid/ready RGB pixel stream for one frame of `FRAME_PIXELS` pixels per `start` pulse and drives the converter's `enable` as a stall signal. It tracks which converter stages hold real pixels and presents the luma results on a valid/ready output with an end-of-frame marker. It sits between the pixel source and the converter, and between the converter and the downstream sink.

## Interface
- `DATA_WIDTH`, 8, per-channel and luma width; must match the converter.
- `FRAME_PIXELS`, 16, pixels per frame; legal range 1 to 65535.
- `CNT_WIDTH`, 16, width of the pixel counter and `stall_count`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: one-cycle pulse that begins a frame; honoured in IDLE only.
- `abort` input 1: ends the frame early; honoured in RUN only.
- `s_valid` input 1, `s_ready` output 1: input pixel handshake.
- `s_red`, `s_green`, `s_blue` input DATA_WIDTH: input pixel.
- `conv_enable` output 1: drives the converter's `enable`.
- `conv_red`, `conv_green`, `conv_blue` output DATA_WIDTH: combinational pass-through of `s_red`, `s_green`, `s_blue`.
- `conv_color` input DATA_WIDTH: the converter's `color_out`.
- `m_valid` output 1, `m_ready` input 1: output handshake.
- `m_data` output DATA_WIDTH: equals `conv_color`.
- `m_last` output 1: marks the final pixel of the frame.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse when a frame has completely drained.
- `aborted` output 1: sticky; set on abort, cleared on the next accepted `start`.
- `stall_count` output CNT_WIDTH: see Configuration.

## Operation
- Converter pipeline model:
  - The converter has 3 stages, all gated by `enable`.
  - Data sampled at edge k appears on `color_out` after the third enabled edge.
- Stage occupancy:
  - `vld[2:0]` records which stages hold a real pixel; `lst[2:0]` records which hold a frame-last pixel.
  - Both shift on every cycle `adv` is high: `vld <= {vld[1:0], s_fire}`, and likewise `lst` takes `s_fire & last_pix`.
  - `s_fire = s_valid & s_ready`.
- Advance rule: `adv = ~vld[2] | m_ready`.
- Output and enable:
  - `m_valid = vld[2]`, `m_last = vld[2] & lst[2]`.
  - `conv_enable = adv & (state != IDLE)`.
- States:
  - IDLE: `s_ready = 0`. A `start` pulse clears `pix_cnt` and `aborted`, then moves to RUN.
  - RUN: `s_ready = adv`. Each `s_fire` increments `pix_cnt`. `last_pix = (pix_cnt == FRAME_PIXELS-1)`. The `s_fire` with `last_pix` high moves to DRAIN.
  - RUN, abort: `abort` moves to DRAIN and sets `aborted`. Abort has priority over a coincident `s_fire`: that pixel is not accepted, because `s_ready` is forced low in any cycle where `abort` is high. No `m_last` is emitted for an aborted frame.
  - DRAIN: `s_ready = 0`. `conv_enable = adv`, which pushes bubbles through the pipeline. When `vld == 0`, move to DONE.
  - DONE: `done = 1` for exactly one cycle, then move to IDLE.
- `start` outside IDLE and `abort` outside RUN are ignored.
- Bubbles inside the pipeline are legal: `m_valid` is low for those slots and no data is lost.
- Reset (asynchronous, including mid-frame):
  - State goes to IDLE; `vld`, `lst`, `pix_cnt`, `stall_count` and `aborted` go to 0.
  - All outputs read 0 except `m_data`, which follows `conv_color`.
  - Any pixels still in the converter are discarded.

## Timing
- Latency: a pixel accepted in cycle n is presented with `m_valid` in cycle n+3 when there is no backpressure.
- Throughput: one pixel per cycle while `m_ready` is high.
- Under backpressure (`m_valid & ~m_ready`):
  - `adv = 0`, so `conv_enable = 0` and `s_ready = 0`.
  - `m_data` and `m_last` hold stable until the handshake completes.
- Frame timing: a full frame of N pixels with no stalls takes `start` in cycle 0, pixels in cycles 1..N, outputs in cycles 4..N+3, and `done` in cycle N+4.
- `busy` falls in the cycle after `done`.

## Configuration
- Macro: `CONVERTER_CTRL_STALL_CNT_EN`.
- When defined:
  - `stall_count` increments in every cycle with `m_valid & ~m_ready`, saturating at all-ones.
  - It clears on an accepted `start`.
- When undefined: `stall_count` is tied to 0 and no counter logic is synthesised.

## Test plan
- Basic frame: `FRAME_PIXELS = 4`, `m_ready` held at 1, pixels (255,255,255), (0,0,0), (100,50,25), (10,200,30).
  - `m_data` = 255, 16, 84, 137 on consecutive cycles 3 after acceptance.
  - `m_last` is set on 137 only; `done` pulses once.
- Backpressure: drop `m_ready` for 5 cycles while the pipeline is full.
  - `conv_enable` and `s_ready` stay low and `m_data` holds.
  - No pixel is lost or duplicated.
  - With the macro defined, `stall_count = 5`.
- Input bubbles: drop `s_valid` in alternating cycles.
  - `m_valid` shows matching gaps and the output order is preserved.
- Abort: assert `abort` after 2 of 4 pixels are accepted.
  - Exactly 2 outputs appear, `m_last` never asserts, `aborted = 1`, and `done` pulses.
- Reset mid-frame: assert `reset` with 2 pixels in flight.
  - `m_valid`, `busy` and `conv_enable` read 0 immediately.
  - A following `start` delivers a clean frame whose first output arrives 3 cycles after acceptance.
- Ignored control: `start` pulsed during RUN has no effect; `abort` pulsed during IDLE has no effect.

Source files
------------

// File: rtl/converter_ctrl.sv
// Frame sequencer around the 3-stage RGB-to-luma converter: input/output valid/ready,
// stage occupancy tracking and frame control. Optional stall counter: CONVERTER_CTRL_STALL_CNT_EN.
module converter_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_PIXELS = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_red,
  input  logic [DATA_WIDTH-1:0] s_green,
  input  logic [DATA_WIDTH-1:0] s_blue,
  output logic                  conv_enable,
  output logic [DATA_WIDTH-1:0] conv_red,
  output logic [DATA_WIDTH-1:0] conv_green,
  output logic [DATA_WIDTH-1:0] conv_blue,
  input  logic [DATA_WIDTH-1:0] conv_color,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [2:0]           vld, lst, vld_nxt;
  logic [CNT_WIDTH-1:0] pix_cnt;
  logic                 adv, s_fire, last_pix;

  // The converter stalls as a whole, so every stage advances only when the
  // output slot is empty or being taken.
  always_comb begin
    adv      = ~vld[2] | m_ready;
    s_ready  = (state == RUN) & adv & ~abort;
    s_fire   = s_valid & s_ready;
    last_pix = (pix_cnt == CNT_WIDTH'(FRAME_PIXELS - 1));
    vld_nxt  = adv ? {vld[1:0], s_fire} : vld;
  end

  assign conv_enable = adv & (state != IDLE);
  assign conv_red    = s_red;
  assign conv_green  = s_green;
  assign conv_blue   = s_blue;
  assign m_valid     = vld[2];
  assign m_last      = vld[2] & lst[2];
  assign m_data      = conv_color;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // NOTE: every flop here is written with <= so all next-state terms read the
  // pre-edge values, exactly like the hardware they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      vld     <= '0;
      lst     <= '0;
      pix_cnt <= '0;
      aborted <= 1'b0;
    end else begin
      if (adv) begin
        vld <= {vld[1:0], s_fire};
        lst <= {lst[1:0], s_fire & last_pix};
      end
      case (state)
        IDLE: if (start) begin
          pix_cnt <= '0;
          aborted <= 1'b0;
          state   <= RUN;
        end
        RUN: if (abort) begin
          aborted <= 1'b1;
          state   <= DRAIN;
        end else if (s_fire) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (last_pix) state <= DRAIN;
        end
        // Leave DRAIN on the edge that empties the pipe so done lands at N+4.
        DRAIN: if (vld_nxt == 3'b000) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONVERTER_CTRL_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_q <= '0;
    else if (state == IDLE && start)
      stall_q <= '0;
    else if (m_valid && !m_ready && stall_q != '1)
      stall_q <= stall_q + 1'b1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_converter_ctrl.sv
// Bench for converter_ctrl: behavioural converter, accept/deliver scoreboard, scenario tasks.
module tb_converter_ctrl;
  localparam int DW = 8;
  localparam int FP = 4;
  localparam int CW = 16;
  localparam logic [63:0] ALL1 = '1;

  logic          clk = 1'b0;
  logic          reset, start, abort, s_valid, s_ready, conv_enable;
  logic [DW-1:0] s_red, s_green, s_blue, conv_red, conv_green, conv_blue, conv_color, m_data;
  logic          m_valid, m_ready, m_last, busy, done, aborted;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  converter_ctrl #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_red(s_red), .s_green(s_green), .s_blue(s_blue),
    .conv_enable(conv_enable),
    .conv_red(conv_red), .conv_green(conv_green), .conv_blue(conv_blue),
    .conv_color(conv_color),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .aborted(aborted), .stall_count(stall_count)
  );

  // Saturating weighted luma; coefficients reproduce the reference pixel values.
  function automatic logic [DW-1:0] luma(input logic [DW-1:0] r, g, b);
    int y;
    y = 16 + ((66 * int'(r) + 124 * int'(g) + 185 * int'(b)) >> 8);
    return (y > 255) ? 8'd255 : 8'(y);
  endfunction

  // Converter stand-in: three enable-gated stages.
  logic [DW-1:0] p1, p2, p3;
  always @(posedge clk) begin
    if (conv_enable) begin
      p1 <= luma(conv_red, conv_green, conv_blue);
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign conv_color = p3;

  // Scoreboard: every accepted pixel must come out once, in order.
  logic [DW:0]   exp_q[$];
  logic [23:0]   px_q[$];
  int            frame_cnt = 0;
  int            n_out = 0, n_last = 0, n_done = 0;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  logic          tr_v[256], tr_l[256], tr_en[256], tr_sr[256], tr_dn[256], tr_busy[256];
  logic [DW-1:0] tr_d[256];

  task automatic sample();
    logic [DW:0] e;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) frame_cnt = 0;
      if (s_valid && s_ready) begin
        exp_q.push_back({frame_cnt == FP - 1, luma(s_red, s_green, s_blue)});
        frame_cnt++;
      end
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: output data=%0d last=%0b, want no output", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            bad++;
            $display("FAIL sb_data: got last=%0b data=%0d, want last=%0b data=%0d",
                     m_last, m_data, e[DW], e[DW-1:0]);
          end
        end
        n_out++;
        if (m_last) n_last++;
      end
      if (prev_stall) begin
        total++;
        if (m_data !== prev_data || m_last !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: got data=%0d last=%0b, want data=%0d last=%0b",
                   m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid && !m_ready) begin
        total++;
        if (conv_enable !== 1'b0 || s_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_gate: got conv_enable=%0b s_ready=%0b, want 0 0", conv_enable, s_ready);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) n_done++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic log_cycle(input int c);
    tr_v[c] = m_valid;  tr_l[c] = m_last;  tr_d[c] = m_data;
    tr_en[c] = conv_enable;  tr_sr[c] = s_ready;  tr_dn[c] = done;  tr_busy[c] = busy;
  endtask

  // Runs one frame from px_q; cycle 0 is the start cycle. Logs one cycle past done.
  task automatic run_frame(input logic [63:0] vmask, input logic [63:0] rmask, input bit rnd,
                           input int abort_cyc, input int start_cyc, input int budget,
                           output int ncyc, output int nsent, output bit got_done);
    bit fired;
    got_done = 1'b0;
    nsent = 0;
    start = 1'b1; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    sample(); log_cycle(0); advance();
    start = 1'b0;
    ncyc = 1;
    while (!got_done && ncyc < budget) begin
      s_valid = (nsent < FP) && (rnd ? ($urandom_range(0, 1) == 1) : (ncyc < 64 ? vmask[ncyc] : 1'b1));
      m_ready = rnd ? ($urandom_range(0, 3) != 0) : (ncyc < 64 ? rmask[ncyc] : 1'b1);
      abort   = (ncyc == abort_cyc);
      start   = (ncyc == start_cyc);
      if (nsent < px_q.size()) {s_red, s_green, s_blue} = px_q[nsent];
      sample(); log_cycle(ncyc);
      fired = s_valid && s_ready;
      if (done) got_done = 1'b1;
      advance();
      if (fired) nsent++;
      ncyc++;
    end
    s_valid = 1'b0; abort = 1'b0; start = 1'b0; m_ready = 1'b1;
    sample(); log_cycle(ncyc); advance();
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL frame_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic load_ref_pixels();
    px_q.delete();
    px_q.push_back({8'd255, 8'd255, 8'd255});
    px_q.push_back({8'd0, 8'd0, 8'd0});
    px_q.push_back({8'd100, 8'd50, 8'd25});
    px_q.push_back({8'd10, 8'd200, 8'd30});
  endtask

  task automatic load_rand_pixels();
    px_q.delete();
    for (int i = 0; i < FP; i++) px_q.push_back(24'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    {s_red, s_green, s_blue} = 24'h123456;
    advance(); advance();
    sample();
    total++;
    if ({s_ready, conv_enable, m_valid, m_last, busy, done, aborted} !== 7'b0 || stall_count !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got sr=%0b en=%0b mv=%0b ml=%0b busy=%0b done=%0b ab=%0b sc=%0d, want all 0",
               s_ready, conv_enable, m_valid, m_last, busy, done, aborted, stall_count);
    end
    total++;
    if (m_data !== conv_color) begin
      bad++;
      $display("FAIL reset_mdata: got %0d, want %0d", m_data, conv_color);
    end
    advance();
    reset = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_basic();
    int ncyc, nsent, o0, l0, d0;
    bit ok;
    logic [DW-1:0] want[4];
    want = '{8'd255, 8'd16, 8'd84, 8'd137};
    load_ref_pixels();
    o0 = n_out; l0 = n_last; d0 = n_done;
    run_frame(ALL1, ALL1, 1'b0, -1, -1, 40, ncyc, nsent, ok);
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (tr_sr[c] !== 1'b1 || tr_v[c] !== (c == 4)) begin
        bad++;
        $display("FAIL basic_in c=%0d: got s_ready=%0b m_valid=%0b, want 1 %0b", c, tr_sr[c], tr_v[c], c == 4);
      end
    end
    for (int c = 4; c <= 7; c++) begin
      total++;
      if (tr_v[c] !== 1'b1 || tr_d[c] !== want[c-4] || tr_l[c] !== (c == 7)) begin
        bad++;
        $display("FAIL basic_out c=%0d: got v=%0b d=%0d l=%0b, want 1 %0d %0b",
                 c, tr_v[c], tr_d[c], tr_l[c], want[c-4], c == 7);
      end
    end
    total++;
    if (tr_dn[8] !== 1'b1 || n_done - d0 != 1 || tr_busy[8] !== 1'b1 || tr_busy[9] !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: got done8=%0b pulses=%0d busy8=%0b busy9=%0b, want 1 1 1 0",
               tr_dn[8], n_done - d0, tr_busy[8], tr_busy[9]);
    end
    total++;
    if (n_out - o0 != 4 || n_last - l0 != 1) begin
      bad++;
      $display("FAIL basic_count: got outs=%0d lasts=%0d, want 4 1", n_out - o0, n_last - l0);
    end
  endtask

  task automatic test_backpressure();
    int ncyc, nsent, o0, l0, exp_sc;
    bit ok;
    load_ref_pixels();
    o0 = n_out; l0 = n_last;
    run_frame(ALL1, ~(64'h1F << 4), 1'b0, -1, -1, 40, ncyc, nsent, ok);
    for (int c = 4; c <= 8; c++) begin
      total++;
      if (tr_en[c] !== 1'b0 || tr_sr[c] !== 1'b0 || tr_v[c] !== 1'b1 || tr_d[c] !== 8'd255) begin
        bad++;
        $display("FAIL bp_stall c=%0d: got en=%0b sr=%0b v=%0b d=%0d, want 0 0 1 255",
                 c, tr_en[c], tr_sr[c], tr_v[c], tr_d[c]);
      end
    end
    total++;
    if (tr_d[10] !== 8'd16 || tr_l[12] !== 1'b1 || tr_d[12] !== 8'd137 || tr_dn[13] !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume: got d10=%0d l12=%0b d12=%0d done13=%0b, want 16 1 137 1",
               tr_d[10], tr_l[12], tr_d[12], tr_dn[13]);
    end
    total++;
    if (n_out - o0 != 4 || n_last - l0 != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got outs=%0d lasts=%0d pending=%0d, want 4 1 0", n_out - o0, n_last - l0, exp_q.size());
    end
`ifdef CONVERTER_CTRL_STALL_CNT_EN
    exp_sc = 5;
`else
    exp_sc = 0;
`endif
    total++;
    if (stall_count !== CW'(exp_sc)) begin
      bad++;
      $display("FAIL bp_stall_count: got %0d, want %0d", stall_count, exp_sc);
    end
  endtask

  task automatic test_bubbles();
    int ncyc, nsent;
    bit ok, want_v;
    load_rand_pixels();
    run_frame({32{2'b10}}, ALL1, 1'b0, -1, -1, 40, ncyc, nsent, ok);
    for (int c = 4; c <= 10; c++) begin
      want_v = (c % 2 == 0);
      total++;
      if (tr_v[c] !== want_v ||
          (want_v && tr_d[c] !== luma(px_q[(c-4)/2][23:16], px_q[(c-4)/2][15:8], px_q[(c-4)/2][7:0]))) begin
        bad++;
        $display("FAIL bubble_out c=%0d: got v=%0b d=%0d, want v=%0b", c, tr_v[c], tr_d[c], want_v);
      end
    end
    total++;
    if (tr_dn[11] !== 1'b1) begin
      bad++;
      $display("FAIL bubble_done: got done11=%0b, want 1", tr_dn[11]);
    end
  endtask

  task automatic test_abort();
    int ncyc, nsent, o0, l0;
    bit ok;
    load_rand_pixels();
    o0 = n_out; l0 = n_last;
    run_frame(ALL1, ALL1, 1'b0, 3, -1, 40, ncyc, nsent, ok);
    total++;
    if (tr_sr[3] !== 1'b0 || nsent != 2) begin
      bad++;
      $display("FAIL abort_gate: got s_ready3=%0b accepted=%0d, want 0 2", tr_sr[3], nsent);
    end
    total++;
    if (n_out - o0 != 2 || n_last - l0 != 0 || aborted !== 1'b1 || tr_dn[6] !== 1'b1) begin
      bad++;
      $display("FAIL abort_result: got outs=%0d lasts=%0d aborted=%0b done6=%0b, want 2 0 1 1",
               n_out - o0, n_last - l0, aborted, tr_dn[6]);
    end
  endtask

  task automatic test_reset_midframe();
    int ncyc, nsent;
    bit ok;
    load_ref_pixels();
    start = 1'b1; m_ready = 1'b1;
    sample(); advance();
    start = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {s_red, s_green, s_blue} = px_q[i];
      sample(); advance();
    end
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || conv_enable !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_now: got mv=%0b busy=%0b en=%0b, want 0 0 0", m_valid, busy, conv_enable);
    end
    sample(); advance();
    reset = 1'b0;
    run_frame(ALL1, ALL1, 1'b0, -1, -1, 40, ncyc, nsent, ok);
    total++;
    if (tr_v[1] !== 1'b0 || tr_v[2] !== 1'b0 || tr_v[3] !== 1'b0 || tr_v[4] !== 1'b1 || tr_d[4] !== 8'd255) begin
      bad++;
      $display("FAIL rst_mid_clean: got v1..4=%0b%0b%0b%0b d4=%0d, want 0001 255",
               tr_v[1], tr_v[2], tr_v[3], tr_v[4], tr_d[4]);
    end
  endtask

  task automatic test_ignored_control();
    int ncyc, nsent, o0, l0;
    bit ok;
    abort = 1'b1;
    sample();
    total++;
    if (busy !== 1'b0 || aborted !== 1'b0) begin
      bad++;
      $display("FAIL idle_abort: got busy=%0b aborted=%0b, want 0 0", busy, aborted);
    end
    advance();
    abort = 1'b0;
    sample();
    total++;
    if (busy !== 1'b0 || aborted !== 1'b0) begin
      bad++;
      $display("FAIL idle_abort_after: got busy=%0b aborted=%0b, want 0 0", busy, aborted);
    end
    advance();
    load_rand_pixels();
    o0 = n_out; l0 = n_last;
    run_frame(ALL1, ALL1, 1'b0, -1, 2, 40, ncyc, nsent, ok);
    total++;
    if (tr_dn[8] !== 1'b1 || n_out - o0 != 4 || n_last - l0 != 1) begin
      bad++;
      $display("FAIL run_start: got done8=%0b outs=%0d lasts=%0d, want 1 4 1", tr_dn[8], n_out - o0, n_last - l0);
    end
  endtask

  task automatic test_random();
    int ncyc, nsent, o0, l0, ab;
    bit ok;
    for (int f = 0; f < 20; f++) begin
      load_rand_pixels();
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
      o0 = n_out; l0 = n_last;
      run_frame(ALL1, ALL1, 1'b1, ab, -1, 200, ncyc, nsent, ok);
      total++;
      if (n_out - o0 != nsent || n_last - l0 != int'(nsent == FP) || aborted !== (nsent < FP) || exp_q.size() != 0) begin
        bad++;
        $display("FAIL rand_frame %0d: got outs=%0d lasts=%0d aborted=%0b pending=%0d, accepted=%0d",
                 f, n_out - o0, n_last - l0, aborted, exp_q.size(), nsent);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_abort();
    test_reset_midframe();
    test_ignored_control();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
